// File: rtl/lcd_pkg.sv
// Shared HD44780 command codes and the state/phase encodings used by the
// scene loader and its bus writer.
package lcd_pkg;

   localparam logic [7:0] CMD_FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
   localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
   localparam logic [7:0] CMD_ENTRY    = 8'h06;
   localparam logic [7:0] CMD_CLEAR    = 8'h01;
   localparam logic [7:0] CMD_CGRAM    = 8'h40;
   localparam logic [7:0] CMD_DDRAM_L0 = 8'h80;
   localparam logic [7:0] CMD_DDRAM_L1 = 8'hC0;

   typedef enum logic [2:0] {
      S_POWER_WAIT,
      S_INIT,
      S_IDLE,
      S_SET_CGRAM,
      S_LOAD_ROWS,
      S_SET_DDRAM,
      S_PLACE
   } state_e;

   typedef enum logic [1:0] {
      PH_IDLE,
      PH_SETUP,
      PH_EN_HIGH,
      PH_WAIT
   } phase_e;

   function automatic logic [7:0] init_cmd(input logic [1:0] idx);
      case (idx)
         2'd0:    return CMD_FUNC_SET;
         2'd1:    return CMD_DISP_ON;
         2'd2:    return CMD_ENTRY;
         default: return CMD_CLEAR;
      endcase
   endfunction

endpackage

// File: rtl/lcd_bus_writer.sv
// Tick-paced single-byte HD44780 write: setup, enable strobe, then settle wait
// (longer after CLEAR). rs/data are held from start until the next start.
module lcd_bus_writer
   import lcd_pkg::*;
#(
   parameter int EN_TICKS       = 1,
   parameter int WAIT_TICKS     = 2,
   parameter int CLR_WAIT_TICKS = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       start,
   input  logic       rs,
   input  logic [7:0] data,
   output logic       ready,
   output logic       lcd_rs,
   output logic       lcd_en,
   output logic [7:0] lcd_data
);

   phase_e     phase_q, phase_d;
   logic [7:0] cnt_q, cnt_d;
   logic       rs_q, rs_d;
   logic [7:0] data_q, data_d;
   logic       is_clear;

   assign is_clear = !rs_q && (data_q == CMD_CLEAR);

   // NOTE: every signal assigned here gets a default first, so no path leaves
   // a value unassigned and no latch is inferred.
   always_comb begin
      phase_d = phase_q;
      cnt_d   = cnt_q;
      rs_d    = rs_q;
      data_d  = data_q;
      case (phase_q)
         PH_IDLE: if (start) begin
            rs_d    = rs;
            data_d  = data;
            cnt_d   = 8'd0;
            phase_d = PH_SETUP;
         end
         PH_SETUP: if (tick) phase_d = PH_EN_HIGH;
         PH_EN_HIGH: if (tick) begin
            if (cnt_q == 8'(EN_TICKS - 1)) begin
               cnt_d   = 8'd0;
               phase_d = PH_WAIT;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         PH_WAIT: if (tick) begin
            if (cnt_q == (is_clear ? 8'(CLR_WAIT_TICKS - 1) : 8'(WAIT_TICKS - 1))) begin
               cnt_d   = 8'd0;
               phase_d = PH_IDLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: phase_d = PH_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (!reset) begin
         phase_q <= PH_IDLE;
         cnt_q   <= 8'd0;
         rs_q    <= 1'b0;
         data_q  <= 8'h00;
      end else begin
         phase_q <= phase_d;
         cnt_q   <= cnt_d;
         rs_q    <= rs_d;
         data_q  <= data_d;
      end
   end

   assign ready    = (phase_q == PH_IDLE);
   assign lcd_en   = (phase_q == PH_EN_HIGH);
   assign lcd_rs   = rs_q;
   assign lcd_data = data_q;

endmodule

// File: rtl/lcd_scene_loader.sv
// HD44780 controller: one-time init, then on request loads a scene of custom
// glyphs from ROM into CGRAM and places them as a tile block on DDRAM.
module lcd_scene_loader
   import lcd_pkg::*;
#(
   parameter int TICK_DIV       = 50000,
   parameter int NUM_GLYPHS     = 8,
   parameter int GLYPHS_PER_ROW = 4,
   parameter int SCENE_W        = 3,
   parameter int EN_TICKS       = 1,
   parameter int WAIT_TICKS     = 2,
   parameter int CLR_WAIT_TICKS = 4,
   parameter int POWER_TICKS    = 40
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               scene_req,
   input  logic [SCENE_W-1:0] scene_sel,
   input  logic [3:0]         col_base,
   output logic               busy,
   output logic               done,
   output logic [SCENE_W+5:0] rom_addr,
   input  logic [7:0]         rom_data,
   output logic               lcd_rs,
   output logic               lcd_rw,
   output logic               lcd_en,
   output logic [7:0]         lcd_data
);

   localparam int TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int LOADS     = NUM_GLYPHS * 8;
   localparam int LAST0     = ((NUM_GLYPHS < GLYPHS_PER_ROW) ? NUM_GLYPHS : GLYPHS_PER_ROW) - 1;
   localparam int LAST1     = ((NUM_GLYPHS < 2 * GLYPHS_PER_ROW) ? NUM_GLYPHS : 2 * GLYPHS_PER_ROW) - 1;
   localparam bit TWO_LINES = NUM_GLYPHS > GLYPHS_PER_ROW;

   state_e             state_q, state_d;
   logic [TW-1:0]      tick_cnt_q, tick_cnt_d;
   logic [15:0]        pw_cnt_q, pw_cnt_d;
   logic [6:0]         idx_q, idx_d;
   logic               line_q, line_d;
   logic               issued_q, issued_d;
   logic               rom_pend_q, rom_pend_d;
   logic [SCENE_W-1:0] scene_q, scene_d;
   logic [5:0]         col_q, col_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic       tick, want_xfer, wr_start, wr_rs, wr_ready;
   logic [7:0] wr_data;
   logic       unused_rom_bits;

   assign tick            = (tick_cnt_q == TW'(TICK_DIV - 1));
   assign unused_rom_bits = ^rom_data[7:5];

   always_comb begin
      state_d    = state_q;
      tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
      pw_cnt_d   = pw_cnt_q;
      idx_d      = idx_q;
      line_d     = line_q;
      issued_d   = issued_q;
      rom_pend_d = rom_pend_q;
      scene_d    = scene_q;
      col_d      = col_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      want_xfer  = 1'b0;
      wr_start   = 1'b0;
      wr_rs      = 1'b0;
      wr_data    = 8'h00;

      case (state_q)
         S_POWER_WAIT: if (tick) begin
            if (pw_cnt_q == 16'(POWER_TICKS - 1)) begin
               pw_cnt_d = 16'd0;
               idx_d    = 7'd0;
               state_d  = S_INIT;
            end else begin
               pw_cnt_d = pw_cnt_q + 16'd1;
            end
         end
         S_INIT: begin
            want_xfer = 1'b1;
            wr_data   = init_cmd(idx_q[1:0]);
         end
         S_IDLE: if (scene_req) begin
            scene_d  = scene_sel;
            col_d    = {2'b00, col_base};
            busy_d   = 1'b1;
            idx_d    = 7'd0;
            line_d   = 1'b0;
            issued_d = 1'b0;
            state_d  = S_SET_CGRAM;
         end
         S_SET_CGRAM: begin
            want_xfer = 1'b1;
            wr_data   = CMD_CGRAM;
         end
         S_LOAD_ROWS: begin
            // Address is presented for one clk before the row byte is handed over.
            want_xfer = rom_pend_q;
            wr_rs     = 1'b1;
            wr_data   = {3'b000, rom_data[4:0]};
            if (!issued_q && !rom_pend_q) rom_pend_d = 1'b1;
         end
         S_SET_DDRAM: begin
            want_xfer = 1'b1;
            wr_data   = (line_q ? CMD_DDRAM_L1 : CMD_DDRAM_L0) | {2'b00, col_q};
         end
         S_PLACE: begin
            want_xfer = 1'b1;
            wr_rs     = 1'b1;
            wr_data   = {1'b0, idx_q};
         end
         default: state_d = S_POWER_WAIT;
      endcase

      if (want_xfer && !issued_q && wr_ready) begin
         wr_start   = 1'b1;
         issued_d   = 1'b1;
         rom_pend_d = 1'b0;
      end

      // Writer back in ready after an issued transfer: advance the sequence.
      if (issued_q && wr_ready) begin
         issued_d = 1'b0;
         case (state_q)
            S_INIT: begin
               if (idx_q == 7'd3) begin
                  idx_d   = 7'd0;
                  busy_d  = 1'b0;
                  state_d = S_IDLE;
               end else begin
                  idx_d = idx_q + 7'd1;
               end
            end
            S_SET_CGRAM: begin
               idx_d   = 7'd0;
               state_d = S_LOAD_ROWS;
            end
            S_LOAD_ROWS: begin
               if (idx_q == 7'(LOADS - 1)) begin
                  idx_d   = 7'd0;
                  line_d  = 1'b0;
                  state_d = S_SET_DDRAM;
               end else begin
                  idx_d = idx_q + 7'd1;
               end
            end
            S_SET_DDRAM: begin
               idx_d   = line_q ? 7'(GLYPHS_PER_ROW) : 7'd0;
               state_d = S_PLACE;
            end
            S_PLACE: begin
               if (idx_q == (line_q ? 7'(LAST1) : 7'(LAST0))) begin
                  if (!line_q && TWO_LINES) begin
                     line_d  = 1'b1;
                     state_d = S_SET_DDRAM;
                  end else begin
                     idx_d   = 7'd0;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                     state_d = S_IDLE;
                  end
               end else begin
                  idx_d = idx_q + 7'd1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= S_POWER_WAIT;
         tick_cnt_q <= '0;
         pw_cnt_q   <= 16'd0;
         idx_q      <= 7'd0;
         line_q     <= 1'b0;
         issued_q   <= 1'b0;
         rom_pend_q <= 1'b0;
         scene_q    <= '0;
         col_q      <= 6'd0;
         busy_q     <= 1'b1;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         pw_cnt_q   <= pw_cnt_d;
         idx_q      <= idx_d;
         line_q     <= line_d;
         issued_q   <= issued_d;
         rom_pend_q <= rom_pend_d;
         scene_q    <= scene_d;
         col_q      <= col_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   lcd_bus_writer #(
      .EN_TICKS       (EN_TICKS),
      .WAIT_TICKS     (WAIT_TICKS),
      .CLR_WAIT_TICKS (CLR_WAIT_TICKS)
   ) u_writer (
      .clk      (clk),
      .reset    (reset),
      .tick     (tick),
      .start    (wr_start),
      .rs       (wr_rs),
      .data     (wr_data),
      .ready    (wr_ready),
      .lcd_rs   (lcd_rs),
      .lcd_en   (lcd_en),
      .lcd_data (lcd_data)
   );

   assign rom_addr = {scene_q, idx_q[5:0]};
   assign busy     = busy_q;
   assign done     = done_q;
   assign lcd_rw   = 1'b0;

endmodule
